// File: rtl/ext_bus_responder.sv
// External-bus responder: request/ready handshake with programmable wait states
// and a word-organised backing store; flags misaligned and PRAM-window accesses.
module ext_bus_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_en,
    input  logic        i_bus_req,
    input  logic        i_bus_we,
    input  logic [15:0] i_bus_addr,
    input  logic [31:0] i_bus_write_data,
    output logic [31:0] o_bus_read_data,
    output logic        i_bus_rdy,
    output logic        bus_err,
    output logic        busy
);

    localparam int unsigned DEPTH     = 1 << ADDR_W;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rdy_q, rdy_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        mem_we;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              req_err;
    logic              unused_addr_hi;

    assign idx            = addr_q[ADDR_W+1:2];
    assign req_err        = (addr_q[1:0] != 2'b00) || (addr_q[15:14] == 2'b00);
    assign unused_addr_hi = ^addr_q[15:ADDR_W+2];

    // WAIT spans WAIT_CYCLES+1 cycles, so the response lands WAIT_CYCLES+1 edges
    // after acceptance and a zero-wait build still serves one request per 3 cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rdy_d   = 1'b0;
        err_d   = 1'b0;
        busy_d  = busy_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (ex_en && i_bus_req) begin
                    addr_d  = i_bus_addr;
                    we_d    = i_bus_we;
                    wdata_d = i_bus_write_data;
                    busy_d  = 1'b1;
                    cnt_d   = WAIT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!ex_en) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    rdy_d   = 1'b1;
                    err_d   = req_err;
                    if (req_err) begin
                        rdata_d = '0;
                    end else if (we_q) begin
                        mem_we  = 1'b1;
                        rdata_d = '0;
                    end else begin
                        rdata_d = mem[idx];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Backing store is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem[idx] <= wdata_q;
        end
    end

    assign o_bus_read_data = rdata_q;
    assign i_bus_rdy       = rdy_q;
    assign bus_err         = err_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_ext_bus_responder.sv
// Directed bench: instance 0 built with 2 wait states, instance 1 with 0 wait states.
module tb_ext_bus_responder;

    logic        clk;
    logic        rst;
    logic        en    [2];
    logic        req   [2];
    logic        we    [2];
    logic [15:0] addr  [2];
    logic [31:0] wd    [2];
    logic [31:0] rd    [2];
    logic        rdy   [2];
    logic        err   [2];
    logic        busy  [2];

    int total;
    int bad;

    ext_bus_responder #(.WAIT_CYCLES(2), .ADDR_W(8)) dut_w2 (
        .clk(clk), .rst(rst), .ex_en(en[0]), .i_bus_req(req[0]), .i_bus_we(we[0]),
        .i_bus_addr(addr[0]), .i_bus_write_data(wd[0]), .o_bus_read_data(rd[0]),
        .i_bus_rdy(rdy[0]), .bus_err(err[0]), .busy(busy[0])
    );

    ext_bus_responder #(.WAIT_CYCLES(0), .ADDR_W(8)) dut_w0 (
        .clk(clk), .rst(rst), .ex_en(en[1]), .i_bus_req(req[1]), .i_bus_we(we[1]),
        .i_bus_addr(addr[1]), .i_bus_write_data(wd[1]), .o_bus_read_data(rd[1]),
        .i_bus_rdy(rdy[1]), .bus_err(err[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One full transaction; expected response lands 3 edges (W=2) or 1 edge (W=0) after acceptance.
    task automatic xfer(input int s, input logic w, input logic [15:0] a, input logic [31:0] d,
                        input logic [31:0] exp_d, input logic exp_e, input string tag);
        int n;
        int lat;
        lat = (s == 0) ? 3 : 1;
        en[s]   = 1'b1;
        req[s]  = 1'b1;
        we[s]   = w;
        addr[s] = a;
        wd[s]   = d;
        tick();
        check({tag, "/busy_acc"}, 32'(busy[s]), 32'd1);
        n = 0;
        while (rdy[s] !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        check({tag, "/latency"}, 32'(n), 32'(lat));
        check({tag, "/rdy"}, 32'(rdy[s]), 32'd1);
        check({tag, "/err"}, 32'(err[s]), 32'(exp_e));
        check({tag, "/data"}, rd[s], exp_d);
        check({tag, "/busy_resp"}, 32'(busy[s]), 32'd1);
        req[s] = 1'b0;
        tick();
        check({tag, "/rdy_pulse"}, 32'(rdy[s]), 32'd0);
        check({tag, "/busy_end"}, 32'(busy[s]), 32'd0);
    endtask

    initial begin
        logic [15:0] b2b_addr [3];
        logic [31:0] b2b_data [3];
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wd[i] = '0;
        end
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset%0d/rdata", i), rd[i], 32'h0);
            check($sformatf("reset%0d/rdy", i), 32'(rdy[i]), 32'd0);
            check($sformatf("reset%0d/err", i), 32'(err[i]), 32'd0);
            check($sformatf("reset%0d/busy", i), 32'(busy[i]), 32'd0);
        end
        rst = 1'b1;
        tick();

        // Preload and basic write/read
        xfer(0, 1'b1, 16'h4000, 32'hA5A5A5A5, 32'h0, 1'b0, "wr4000");
        xfer(0, 1'b1, 16'h4020, 32'h00000000, 32'h0, 1'b0, "wr4020");
        xfer(0, 1'b1, 16'h4010, 32'hDEADBEEF, 32'h0, 1'b0, "wr4010");
        xfer(0, 1'b0, 16'h4010, 32'h0, 32'hDEADBEEF, 1'b0, "rd4010");

        // Error cases
        xfer(0, 1'b0, 16'h4012, 32'h0, 32'h0, 1'b1, "rd_misal");
        xfer(0, 1'b1, 16'h1000, 32'h12345678, 32'h0, 1'b1, "wr_pram");
        xfer(0, 1'b0, 16'h1000, 32'h0, 32'h0, 1'b1, "rd_pram");
        xfer(0, 1'b0, 16'h4000, 32'h0, 32'hA5A5A5A5, 1'b0, "rd4000");

        // Aliasing
        xfer(0, 1'b1, 16'h4004, 32'h11111111, 32'h0, 1'b0, "wr4004");
        xfer(0, 1'b0, 16'h4404, 32'h0, 32'h11111111, 1'b0, "rd4404");

        // Abort by dropping ex_en during WAIT
        en[0] = 1'b1; req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h4020; wd[0] = 32'hCAFEF00D;
        tick();
        req[0] = 1'b0;
        tick();
        en[0] = 1'b0;
        tick();
        check("abort/busy", 32'(busy[0]), 32'd0);
        check("abort/rdy", 32'(rdy[0]), 32'd0);
        en[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort/no_rdy", 32'(rdy[0]), 32'd0);
        end
        xfer(0, 1'b0, 16'h4020, 32'h0, 32'h00000000, 1'b0, "rd4020_abort");

        // Reset during WAIT after accepting a write
        xfer(0, 1'b1, 16'h4030, 32'h33333333, 32'h0, 1'b0, "wr4030");
        xfer(0, 1'b0, 16'h4010, 32'h0, 32'hDEADBEEF, 1'b0, "rd4010_b");
        en[0] = 1'b1; req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h4030; wd[0] = 32'h77777777;
        tick();
        req[0] = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("midrst/rdata", rd[0], 32'h0);
        check("midrst/rdy", 32'(rdy[0]), 32'd0);
        check("midrst/err", 32'(err[0]), 32'd0);
        check("midrst/busy", 32'(busy[0]), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst/no_rdy", 32'(rdy[0]), 32'd0);
        end
        xfer(0, 1'b0, 16'h4030, 32'h0, 32'h33333333, 1'b0, "rd4030_rst");

        // Zero-wait build: preload then back-to-back reads with request held
        b2b_addr[0] = 16'h4040; b2b_data[0] = 32'h01010101;
        b2b_addr[1] = 16'h4044; b2b_data[1] = 32'h02020202;
        b2b_addr[2] = 16'h4048; b2b_data[2] = 32'h03030303;
        for (int i = 0; i < 3; i++) begin
            xfer(1, 1'b1, b2b_addr[i], b2b_data[i], 32'h0, 1'b0, $sformatf("w0_wr%0d", i));
        end
        en[1] = 1'b1; req[1] = 1'b1; we[1] = 1'b0; addr[1] = b2b_addr[0];
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("b2b%0d/acc_rdy", i), 32'(rdy[1]), 32'd0);
            check($sformatf("b2b%0d/acc_busy", i), 32'(busy[1]), 32'd1);
            tick();
            check($sformatf("b2b%0d/rdy", i), 32'(rdy[1]), 32'd1);
            check($sformatf("b2b%0d/data", i), rd[1], b2b_data[i]);
            check($sformatf("b2b%0d/err", i), 32'(err[1]), 32'd0);
            if (i < 2) addr[1] = b2b_addr[i+1];
            else req[1] = 1'b0;
            tick();
            check($sformatf("b2b%0d/idle_rdy", i), 32'(rdy[1]), 32'd0);
            check($sformatf("b2b%0d/idle_busy", i), 32'(busy[1]), 32'd0);
        end
        tick();
        check("b2b/done_rdy", 32'(rdy[1]), 32'd0);
        check("b2b/data_hold", rd[1], 32'h03030303);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
